pipe_stage_ctrl: RTL

- Parametrised successor to the fixed four-phase stall clock generator that feeds fetch/decode/execute/rf in core_top.
- Produces per-stage clock enables for an N-stage pipeline. Tracks a valid (bubble) bit per stage.
- Supports per-stage stall requests, per-stage flush and an interrupt drain/acknowledge sequence.
- Sits in the core top level between PS/memory stall sources and every pipelined sub-block.

---
 rtl/pipe_stage_ctrl_pkg.sv | 9 +
 rtl/pipe_stage_ctrl_if.sv | 26 ++
 rtl/pipe_vld_chain.sv | 28 ++
 rtl/pipe_stage_ctrl.sv | 61 ++++++
 4 files changed

// File: rtl/pipe_stage_ctrl_pkg.sv
// pipe_stage_ctrl_pkg: shared FSM encoding, default depth and stage indices for the pipeline controller
package pipe_stage_ctrl_pkg;
   typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, ACK = 2'd2} state_t;
   localparam int NUM_STAGES_DEF = 4;
   localparam int STG_FETCH = 0;
   localparam int STG_DCD   = 1;
   localparam int STG_EXE   = 2;
   localparam int STG_RF    = 3;
endpackage

// File: rtl/pipe_stage_ctrl_if.sv
// pipe_stage_ctrl_if: stall/flush/interrupt inputs and enable/valid/ack/count outputs; master = stall sources, slave = controller
interface pipe_stage_ctrl_if
   import pipe_stage_ctrl_pkg::*;
#(
   parameter int NUM_STAGES = NUM_STAGES_DEF,
   parameter int CNT_W      = 16
) ();
   logic                  stallb;
   logic [NUM_STAGES-1:0] stall_req;
   logic [NUM_STAGES-1:0] flush_req;
   logic                  interrupt;
   logic                  int_mask;
   logic [NUM_STAGES-1:0] stg_en;
   logic [NUM_STAGES-1:0] stg_vld;
   logic                  int_ack;
   logic                  draining;
   logic [CNT_W-1:0]      stall_cnt;
   modport master (
      output stallb, stall_req, flush_req, interrupt, int_mask,
      input  stg_en, stg_vld, int_ack, draining, stall_cnt
   );
   modport slave (
      input  stallb, stall_req, flush_req, interrupt, int_mask,
      output stg_en, stg_vld, int_ack, draining, stall_cnt
   );
endinterface

// File: rtl/pipe_vld_chain.sv
// pipe_vld_chain: hold mask, stage enables and valid/bubble chain; in stallb/stall_req/flush_req/fetch_ok, out stg_en/stg_vld
module pipe_vld_chain #(
   parameter int NUM_STAGES = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  stallb,
   input  logic [NUM_STAGES-1:0] stall_req,
   input  logic [NUM_STAGES-1:0] flush_req,
   input  logic                  fetch_ok,
   output logic [NUM_STAGES-1:0] stg_en,
   output logic [NUM_STAGES-1:0] stg_vld
);
   logic [NUM_STAGES-1:0] hold;
   logic [NUM_STAGES-1:0] src;
   for (genvar g = 0; g < NUM_STAGES; g++) begin : g_stg
      assign hold[g] = |stall_req[NUM_STAGES-1:g];
      if (g == 0) begin : g_head
         assign src[g] = fetch_ok;
      end else begin : g_body
         assign src[g] = stg_en[g-1] & stg_vld[g-1];
      end
   end
   assign stg_en = {NUM_STAGES{stallb}} & ~hold;
   always_ff @(posedge clk or posedge reset)
      if (reset) stg_vld <= '0;
      else stg_vld <= ~flush_req & ((stg_en & src) | (~stg_en & stg_vld));
endmodule

// File: rtl/pipe_stage_ctrl.sv
// pipe_stage_ctrl: N-stage enable/valid controller with interrupt drain; ports clk, reset, bus (slave: stalls/flush/irq in; en/vld/ack/draining/stall_cnt out)
module pipe_stage_ctrl
   import pipe_stage_ctrl_pkg::*;
#(
   parameter int NUM_STAGES = NUM_STAGES_DEF,
   parameter int DRAIN_MAX  = 15,
   parameter int CNT_W      = 16
) (
   input logic              clk,
   input logic              reset,
   pipe_stage_ctrl_if.slave bus
);
   localparam int DW = $clog2(DRAIN_MAX + 1);
   state_t           state, state_n;
   logic [DW-1:0]    dcnt, dcnt_n, dcnt_inc;
   logic             int_pend, int_accept, fetch_ok;
   logic [CNT_W-1:0] scnt;
   pipe_vld_chain #(.NUM_STAGES(NUM_STAGES)) u_chain (
      .clk       (clk),
      .reset     (reset),
      .stallb    (bus.stallb),
      .stall_req (bus.stall_req),
      .flush_req (bus.flush_req),
      .fetch_ok  (fetch_ok),
      .stg_en    (bus.stg_en),
      .stg_vld   (bus.stg_vld)
   );
   always_comb begin
      int_accept = int_pend & (state == RUN) & bus.stallb;
      fetch_ok   = (state == RUN) & ~int_accept;
      dcnt_inc   = (bus.stallb && dcnt != DW'(DRAIN_MAX)) ? dcnt + DW'(1) : dcnt;
      state_n    = state;
      dcnt_n     = dcnt;
      case (state)
         RUN: if (int_accept) begin
            state_n = DRAIN;
            dcnt_n  = '0;
         end
         DRAIN: begin
            dcnt_n  = dcnt_inc;
            state_n = (bus.stg_vld == '0 || dcnt_inc == DW'(DRAIN_MAX)) ? ACK : DRAIN;
         end
         default: state_n = RUN;
      endcase
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state    <= RUN;
         dcnt     <= '0;
         int_pend <= 1'b0;
         scnt     <= '0;
      end else begin
         state    <= state_n;
         dcnt     <= dcnt_n;
         int_pend <= (bus.interrupt & ~bus.int_mask) | (int_pend & (state != ACK));
         if ((~bus.stallb | (|bus.stall_req)) & ~(&scnt)) scnt <= scnt + CNT_W'(1);
      end
   assign bus.int_ack   = (state == ACK);
   assign bus.draining  = (state == DRAIN);
   assign bus.stall_cnt = scnt;
endmodule
